// File: rtl/spu_reg_file.sv
// spu_reg_file: 128 x 128-bit SPU register file.
// Three registered read ports (ra/rb/rc) and two write ports (even/odd pipe).
// When both write ports target the same entry, the odd pipe's data is stored
// and wr_conflict pulses for one cycle.
// Optional macro RF_BYPASS_EN: when defined, same-cycle writes are forwarded
// to matching reads (write-through). When undefined, reads return the array
// contents from before the edge (read-before-write).
module spu_reg_file #(
    parameter int NUM_REGS = 128,
    parameter int WIDTH    = 128,
    parameter int ADDR_W   = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic [ADDR_W-1:0] rc_addr,
    input  logic              wr_even_en,
    input  logic [ADDR_W-1:0] wr_even_addr,
    input  logic [WIDTH-1:0]  wr_even_data,
    input  logic              wr_odd_en,
    input  logic [ADDR_W-1:0] wr_odd_addr,
    input  logic [WIDTH-1:0]  wr_odd_data,
    output logic [WIDTH-1:0]  ra,
    output logic [WIDTH-1:0]  rb,
    output logic [WIDTH-1:0]  rc,
    output logic              wr_conflict
);

    logic [WIDTH-1:0] mem [NUM_REGS];

    logic [WIDTH-1:0] ra_next;
    logic [WIDTH-1:0] rb_next;
    logic [WIDTH-1:0] rc_next;
    logic             same_dest;

`ifdef RF_BYPASS_EN
    // Write-through: the odd pipe is later in program order, so it wins over even.
    function automatic logic [WIDTH-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [WIDTH-1:0]  stored,
        input logic              even_en,
        input logic [ADDR_W-1:0] even_addr,
        input logic [WIDTH-1:0]  even_data,
        input logic              odd_en,
        input logic [ADDR_W-1:0] odd_addr,
        input logic [WIDTH-1:0]  odd_data
    );
        logic [WIDTH-1:0] result;
        result = stored;
        if (odd_en && (odd_addr == addr)) begin
            result = odd_data;
        end else if (even_en && (even_addr == addr)) begin
            result = even_data;
        end
        return result;
    endfunction

    // Operand selection with same-cycle write forwarding.
    always_comb begin
        ra_next = read_port(ra_addr, mem[ra_addr], wr_even_en, wr_even_addr, wr_even_data,
                            wr_odd_en, wr_odd_addr, wr_odd_data);
        rb_next = read_port(rb_addr, mem[rb_addr], wr_even_en, wr_even_addr, wr_even_data,
                            wr_odd_en, wr_odd_addr, wr_odd_data);
        rc_next = read_port(rc_addr, mem[rc_addr], wr_even_en, wr_even_addr, wr_even_data,
                            wr_odd_en, wr_odd_addr, wr_odd_data);
    end
`else
    // Read-before-write: operands come straight from the array.
    always_comb begin
        ra_next = mem[ra_addr];
        rb_next = mem[rb_addr];
        rc_next = mem[rc_addr];
    end
`endif

    // Detect both pipes writing the same destination in this cycle.
    always_comb begin
        same_dest = wr_even_en && wr_odd_en && (wr_even_addr == wr_odd_addr);
    end

    // Array update: the odd write is issued last, so it overrides even on a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_even_en) begin
                mem[wr_even_addr] <= wr_even_data;
            end
            if (wr_odd_en) begin
                mem[wr_odd_addr] <= wr_odd_data;
            end
        end
    end

    // Operand registers hold under stall; the conflict pulse updates every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ra          <= '0;
            rb          <= '0;
            rc          <= '0;
            wr_conflict <= 1'b0;
        end else begin
            wr_conflict <= same_dest;
            if (!stall) begin
                ra <= ra_next;
                rb <= rb_next;
                rc <= rc_next;
            end
        end
    end

endmodule

// File: tb/tb_spu_reg_file.sv
// Testbench for spu_reg_file: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_spu_reg_file;

    localparam int NUM_REGS = 128;
    localparam int WIDTH    = 128;
    localparam int ADDR_W   = 7;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              stall = 1'b0;
    logic [ADDR_W-1:0] ra_addr = '0, rb_addr = '0, rc_addr = '0;
    logic              wr_even_en = 1'b0, wr_odd_en = 1'b0;
    logic [ADDR_W-1:0] wr_even_addr = '0, wr_odd_addr = '0;
    logic [WIDTH-1:0]  wr_even_data = '0, wr_odd_data = '0;
    logic [WIDTH-1:0]  ra, rb, rc;
    logic              wr_conflict;

    int vectors = 0;
    int miscompares = 0;

    spu_reg_file #(.NUM_REGS(NUM_REGS), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
        .wr_even_en(wr_even_en), .wr_even_addr(wr_even_addr), .wr_even_data(wr_even_data),
        .wr_odd_en(wr_odd_en), .wr_odd_addr(wr_odd_addr), .wr_odd_data(wr_odd_data),
        .ra(ra), .rb(rb), .rc(rc), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register contents as a plain array plus expected outputs.
    logic [WIDTH-1:0] m [NUM_REGS];
    logic [WIDTH-1:0] exp_ra = '0, exp_rb = '0, exp_rc = '0;
    logic             exp_conf = 1'b0;
    bit               model_ok = 1'b0;

    function automatic logic [WIDTH-1:0] model_read(input logic [ADDR_W-1:0] a);
        if (BYP && wr_odd_en && wr_odd_addr == a) return wr_odd_data;
        if (BYP && wr_even_en && wr_even_addr == a) return wr_even_data;
        return m[a];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) m[i] = '0;
            exp_ra = '0; exp_rb = '0; exp_rc = '0; exp_conf = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (!stall) begin
                exp_ra = model_read(ra_addr);
                exp_rb = model_read(rb_addr);
                exp_rc = model_read(rc_addr);
            end
            exp_conf = wr_even_en && wr_odd_en && (wr_even_addr == wr_odd_addr);
            if (wr_even_en) m[wr_even_addr] = wr_even_data;
            if (wr_odd_en) m[wr_odd_addr] = wr_odd_data;
        end
    end

    // Compare DUT against the model on the falling edge, once the model is seeded by reset.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_ra", ra, exp_ra);
            chk("model_rb", rb, exp_rb);
            chk("model_rc", rc, exp_rc);
            chk("model_conf", {{(WIDTH-1){1'b0}}, wr_conflict}, {{(WIDTH-1){1'b0}}, exp_conf});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_even_en = 1'b0;
        wr_odd_en  = 1'b0;
        stall      = 1'b0;
        reset      = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [WIDTH-1:0] P_ONE  = {8{16'h0001}};
    localparam logic [WIDTH-1:0] P_AAAA = {8{16'hAAAA}};
    localparam logic [WIDTH-1:0] P_5555 = {8{16'h5555}};
    localparam logic [WIDTH-1:0] P_DB   = {4{32'hDEADBEEF}};
    localparam logic [WIDTH-1:0] P_X    = {4{32'h1234_5678}};
    localparam logic [WIDTH-1:0] P_Y    = {4{32'h8765_4321}};
    localparam logic [WIDTH-1:0] P_0123 = {8{16'h0123}};
    localparam logic [WIDTH-1:0] ONES   = {WIDTH{1'b1}};

    initial begin
        reset = 1'b1;
        step();
        step();
        chk("reset_ra", ra, '0);
        chk("reset_conf", {{(WIDTH-1){1'b0}}, wr_conflict}, '0);
        idle();

        // 1: write then read
        wr_even_en = 1'b1; wr_even_addr = 7'd5; wr_even_data = P_ONE;
        step();
        idle(); ra_addr = 7'd5; rb_addr = 7'd0; rc_addr = 7'd0;
        step();
        chk("t1_ra", ra, P_ONE);
        chk("t1_rb", rb, '0);
        chk("t1_rc", rc, '0);

        // 2: write/write collision, odd wins
        wr_even_en = 1'b1; wr_even_addr = 7'd9; wr_even_data = P_AAAA;
        wr_odd_en  = 1'b1; wr_odd_addr  = 7'd9; wr_odd_data  = P_5555;
        step();
        chk("t2_conf_pulse", {{(WIDTH-1){1'b0}}, wr_conflict}, 1);
        idle(); ra_addr = 7'd9;
        step();
        chk("t2_conf_clear", {{(WIDTH-1){1'b0}}, wr_conflict}, 0);
        chk("t2_ra", ra, P_5555);

        // 3: write/read same cycle
        wr_odd_en = 1'b1; wr_odd_addr = 7'd12; wr_odd_data = P_DB; ra_addr = 7'd12;
        step();
        chk("t3_same_cycle", ra, BYP ? P_DB : '0);
        idle();
        step();
        chk("t3_next_cycle", ra, P_DB);

        // 4: stall holds outputs while writes still commit
        wr_even_en = 1'b1; wr_even_addr = 7'd3; wr_even_data = P_X;
        step();
        idle(); ra_addr = 7'd3;
        step();
        chk("t4_hold_val", ra, P_X);
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1; ra_addr = 7'd7;
            wr_even_en = 1'b1; wr_even_addr = 7'd3; wr_even_data = P_Y;
            step();
            chk("t4_stalled", ra, P_X);
        end
        idle(); ra_addr = 7'd3;
        step();
        chk("t4_after_stall", ra, P_Y);

        // 5: boundary addresses and duplicate read addresses
        wr_even_en = 1'b1; wr_even_addr = 7'd127; wr_even_data = ONES;
        wr_odd_en  = 1'b1; wr_odd_addr  = 7'd0;   wr_odd_data  = P_0123;
        step();
        idle(); ra_addr = 7'd127; rb_addr = 7'd0; rc_addr = 7'd127;
        step();
        chk("t5_ra", ra, ONES);
        chk("t5_rb", rb, P_0123);
        chk("t5_rc", rc, ONES);

        // 6: reset wins over a concurrent write
        wr_even_en = 1'b1; wr_even_addr = 7'd20; wr_even_data = P_X;
        wr_odd_en  = 1'b1; wr_odd_addr  = 7'd20; wr_odd_data  = P_Y;
        step();
        reset = 1'b1; wr_even_en = 1'b1; wr_even_addr = 7'd21; wr_even_data = P_Y;
        wr_odd_en = 1'b0; ra_addr = 7'd20;
        step();
        chk("t6_ra_rst", ra, '0);
        chk("t6_rb_rst", rb, '0);
        chk("t6_rc_rst", rc, '0);
        chk("t6_conf_rst", {{(WIDTH-1){1'b0}}, wr_conflict}, 0);
        idle(); ra_addr = 7'd20; rb_addr = 7'd21; rc_addr = 7'd20;
        step();
        chk("t6_ra_20", ra, '0);
        chk("t6_rb_21", rb, '0);

        // Randomized traffic on a narrow address window to provoke collisions.
        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 99) == 0);
            stall        = ($urandom_range(0, 3) == 0);
            ra_addr      = ($urandom_range(0, 9) == 0) ? 7'd127 : 7'($urandom_range(0, 15));
            rb_addr      = 7'($urandom_range(0, 15));
            rc_addr      = ($urandom_range(0, 4) == 0) ? ra_addr : 7'($urandom_range(0, 15));
            wr_even_en   = $urandom_range(0, 1) == 1;
            wr_even_addr = 7'($urandom_range(0, 15));
            wr_even_data = rnd128();
            wr_odd_en    = $urandom_range(0, 1) == 1;
            wr_odd_addr  = ($urandom_range(0, 2) == 0) ? wr_even_addr : 7'($urandom_range(0, 15));
            wr_odd_data  = rnd128();
            step();
        end
        idle();
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
